est_cfg_sequencer: RTL

EST_CFG_SEQUENCER -- requirements
Module: est_cfg_sequencer

---
 rtl/est_cfg_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/est_cfg_sequencer.sv
// est_cfg_sequencer: loads a weight into the estimator, then tracks its output
// for lock, full-scale saturation and loss of samples (timeout).
module est_cfg_sequencer #(
    parameter logic [3:0] W_DEFAULT = 4'h8,
    parameter int         HOLD_CYC  = 3,
    parameter int         SETTLE_N  = 4,
    parameter int         LOCK_TOL  = 2,
    parameter int         LOCK_CNT  = 4,
    parameter int         TIMEOUT   = 4095
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              cfg_req,
    input  logic [3:0]        cfg_w,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              l_r,
    output logic [3:0]        W_ext,
    input  logic              est_data_ready,
    input  logic signed [7:0] est_y,
    output logic signed [7:0] y_hold,
    output logic              locked,
    output logic              sat,
    output logic              timeout
);
    localparam int HW = $clog2(HOLD_CYC);
    localparam int SW = $clog2(SETTLE_N + 1);
    localparam int LW = $clog2(LOCK_CNT + 1);
    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, TRACK} state_t;
    state_t            state;
    logic [HW-1:0]     hold_cnt;
    logic [SW-1:0]     settle_cnt;
    logic [LW-1:0]     stable_cnt;
    logic [LW-1:0]     stable_nxt;
    logic [11:0]       idle_cnt;
    logic              first;
    logic signed [8:0] diff;
    logic [8:0]        mag;
    logic              accept_cfg;
    logic              active;
    always_comb begin
        diff       = {est_y[7], est_y} - {y_hold[7], y_hold};
        mag        = diff[8] ? $unsigned(-diff) : $unsigned(diff);
        stable_nxt = first ? '0 :
                     (mag <= 9'(LOCK_TOL)) ? ((stable_cnt == LW'(LOCK_CNT)) ? stable_cnt : stable_cnt + 1'b1) :
                     '0;
        accept_cfg = cfg_req && (state == IDLE || state == TRACK);
        active     = state == SETTLE || state == TRACK;
    end
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state      <= IDLE;
            W_ext      <= W_DEFAULT;
            l_r        <= 1'b0;
            cfg_busy   <= 1'b0;
            cfg_done   <= 1'b0;
            y_hold     <= '0;
            locked     <= 1'b0;
            sat        <= 1'b0;
            timeout    <= 1'b0;
            hold_cnt   <= '0;
            settle_cnt <= '0;
            stable_cnt <= '0;
            idle_cnt   <= '0;
            first      <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            if (accept_cfg) begin
                state    <= LOAD;
                W_ext    <= cfg_w;
                l_r      <= 1'b1;
                cfg_busy <= 1'b1;
                timeout  <= 1'b0;
                locked   <= 1'b0;
                hold_cnt <= '0;
            end else if (state == LOAD) begin
                if (hold_cnt == HW'(HOLD_CYC - 1)) begin
                    state      <= SETTLE;
                    l_r        <= 1'b0;
                    cfg_done   <= 1'b1;
                    settle_cnt <= '0;
                    idle_cnt   <= '0;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end else if (active) begin
                if (est_data_ready)
                    idle_cnt <= '0;
                else if (idle_cnt != 12'(TIMEOUT))
                    idle_cnt <= idle_cnt + 1'b1;
                // the estimator went silent: flag it but keep the current state
                if (!est_data_ready && idle_cnt == 12'(TIMEOUT - 1)) begin
                    timeout    <= 1'b1;
                    locked     <= 1'b0;
                    stable_cnt <= '0;
                end
                if (state == SETTLE && est_data_ready) begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == SW'(SETTLE_N - 1)) begin
                        state    <= TRACK;
                        cfg_busy <= 1'b0;
                        first    <= 1'b1;
                    end
                end
                if (state == TRACK && est_data_ready) begin
                    y_hold     <= est_y;
                    sat        <= est_y == 8'sd127 || est_y == -8'sd128;
                    first      <= 1'b0;
                    stable_cnt <= stable_nxt;
                    locked     <= stable_nxt == LW'(LOCK_CNT);
                end
            end
        end
    end
endmodule
